// File: rtl/frame_pkg.sv
// Shared frame layout: beat indices, register map, FSM states.
// Used by frame_transmitter and frame_receptor.
package frame_pkg;

   localparam logic [3:0] HDR_BEATS  = 4'd10;
   localparam logic [3:0] DST_BEAT0  = 4'd3;
   localparam logic [3:0] SRC_BEAT0  = 4'd6;
   localparam logic [3:0] ETYPE_BEAT = 4'd9;

   localparam logic [7:0] ADDR_DST0     = 8'd0;
   localparam logic [7:0] ADDR_SRC0     = 8'd6;
   localparam logic [7:0] ADDR_ETYPE_LO = 8'd12;
   localparam logic [7:0] ADDR_ETYPE_HI = 8'd13;
   localparam logic [7:0] ADDR_LEN      = 8'd14;
   localparam logic [7:0] ADDR_IFG      = 8'd15;
   localparam logic [7:0] ADDR_FRAMES   = 8'd16;
   localparam logic [7:0] ADDR_CTRL     = 8'd17;
   localparam logic [7:0] ADDR_STATUS   = 8'd18;
   localparam logic [7:0] ADDR_SENT     = 8'd19;
   localparam logic [7:0] ADDR_CSUM0    = 8'd20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_GAP
   } fsm_state_t;

endpackage

// File: rtl/frame_transmitter_if.sv
// Avalon-MM slave bus plus AXI-stream egress of frame_transmitter.
// slave: DUT side (Avalon slave, stream source); master: driver side.
interface frame_transmitter_if;

   logic [7:0]  writedata;
   logic        write;
   logic        chipselect;
   logic [7:0]  address;
   logic        read;
   logic [7:0]  readdata;
   logic [15:0] egress_port_tdata;
   logic        egress_port_tvalid;
   logic        egress_port_tready;
   logic        egress_port_tlast;

   modport slave (
      input  writedata, write, chipselect,
      input  address, read,
      output readdata,
      output egress_port_tdata,
      output egress_port_tvalid,
      output egress_port_tlast,
      input  egress_port_tready
   );

   modport master (
      output writedata, write, chipselect,
      output address, read,
      input  readdata,
      input  egress_port_tdata,
      input  egress_port_tvalid,
      input  egress_port_tlast,
      output egress_port_tready
   );

endinterface

// File: rtl/frame_tx_regs.sv
// Register file of frame_transmitter: config regs 0-16, control
// strobes, header shadow copy and registered readback mux.
module frame_tx_regs
   import frame_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [7:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   input  logic        capture,
   input  logic        busy,
   input  logic        stop_pend,
   input  logic [7:0]  frames_sent,
   input  logic [31:0] csum,
   output logic        start_req,
   output logic        stop_req,
   output logic [47:0] sh_dst,
   output logic [47:0] sh_src,
   output logic [15:0] sh_etype,
   output logic [7:0]  sh_len,
   output logic [7:0]  ifg,
   output logic [7:0]  frames
);

   logic [7:0] cfg [0:16];
   logic       wr_en;
   logic       rd_en;
   logic       ctrl_wr;
   logic [7:0] rd_mux;

   assign wr_en   = chipselect && write;
   assign rd_en   = chipselect && read;
   assign ctrl_wr = wr_en && (address == ADDR_CTRL);

   // stop wins over a simultaneous start
   assign start_req = ctrl_wr && writedata[0] && !writedata[1];
   assign stop_req  = ctrl_wr && writedata[1];

   assign ifg    = cfg[ADDR_IFG[4:0]];
   assign frames = cfg[ADDR_FRAMES[4:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 17; i++) cfg[i] <= '0;
      end else if (wr_en && address <= ADDR_FRAMES) begin
         cfg[address[4:0]] <= writedata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_dst   <= '0;
         sh_src   <= '0;
         sh_etype <= '0;
         sh_len   <= '0;
      end else if (capture) begin
         sh_dst   <= {cfg[5], cfg[4], cfg[3],
                      cfg[2], cfg[1], cfg[0]};
         sh_src   <= {cfg[11], cfg[10], cfg[9],
                      cfg[8], cfg[7], cfg[6]};
         sh_etype <= {cfg[ADDR_ETYPE_HI[4:0]],
                      cfg[ADDR_ETYPE_LO[4:0]]};
         sh_len   <= cfg[ADDR_LEN[4:0]];
      end
   end

   always_comb begin
      rd_mux = '0;
      if (address <= ADDR_FRAMES) begin
         rd_mux = cfg[address[4:0]];
      end else begin
         case (address)
            ADDR_STATUS:          rd_mux = {6'd0, stop_pend, busy};
            ADDR_SENT:            rd_mux = frames_sent;
            ADDR_CSUM0:           rd_mux = csum[7:0];
            ADDR_CSUM0 + 8'd1:    rd_mux = csum[15:8];
            ADDR_CSUM0 + 8'd2:    rd_mux = csum[23:16];
            ADDR_CSUM0 + 8'd3:    rd_mux = csum[31:24];
            default:              rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_en ? rd_mux : 8'h00;
   end

endmodule

// File: rtl/frame_transmitter.sv
// Avalon-configured AXI-stream frame generator: 10 header beats then
// payload. Optional LFSR payload via `define FRAME_TX_LFSR_EN.
// Ports: clk, reset (async, active-high), bus (frame_transmitter_if.slave).
module frame_transmitter
   import frame_pkg::*;
#(
   parameter logic [15:0] PREAMBLE_WORD = 16'h5555,
   parameter logic [15:0] SFD_WORD      = 16'h55D5
)(
   input logic                clk,
   input logic                reset,
   frame_transmitter_if.slave bus
);

   fsm_state_t  state;
   fsm_state_t  state_n;
   logic [3:0]  beat;
   logic [7:0]  pcnt;
   logic [7:0]  gcnt;
   logic [7:0]  run_cnt;
   logic [7:0]  frames_sent;
   logic [31:0] acc;
   logic [31:0] csum;
   logic        stop_pend;
   logic        capture;
   logic        start_req;
   logic        stop_req;
   logic [47:0] sh_dst;
   logic [47:0] sh_src;
   logic [15:0] sh_etype;
   logic [7:0]  sh_len;
   logic [7:0]  ifg;
   logic [7:0]  frames;
   logic [15:0] tdata;
   logic [15:0] pay_word;
   logic        tvalid;
   logic        tlast;
   logic        hs;
   logic        start_acc;
   logic        last_hs;
   logic [7:0]  len_m1;
   logic        stopping;
   logic        done_now;
   logic        run_done;

   frame_tx_regs u_regs (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (bus.chipselect),
      .write       (bus.write),
      .read        (bus.read),
      .address     (bus.address),
      .writedata   (bus.writedata),
      .readdata    (bus.readdata),
      .capture     (capture),
      .busy        (state != ST_IDLE),
      .stop_pend   (stop_pend),
      .frames_sent (frames_sent),
      .csum        (csum),
      .start_req   (start_req),
      .stop_req    (stop_req),
      .sh_dst      (sh_dst),
      .sh_src      (sh_src),
      .sh_etype    (sh_etype),
      .sh_len      (sh_len),
      .ifg         (ifg),
      .frames      (frames)
   );

   assign bus.egress_port_tdata  = tdata;
   assign bus.egress_port_tvalid = tvalid;
   assign bus.egress_port_tlast  = tlast;

   // length 0 behaves as a single payload beat
   assign len_m1 = (sh_len == 8'd0) ? 8'd0 : sh_len - 8'd1;

   assign tvalid    = (state == ST_HEADER) || (state == ST_PAYLOAD);
   assign tlast     = (state == ST_PAYLOAD) && (pcnt == len_m1);
   assign hs        = tvalid && bus.egress_port_tready;
   assign last_hs   = hs && tlast;
   assign start_acc = (state == ST_IDLE) && start_req;
   assign stopping  = stop_pend || stop_req;

   // done_now sees run_cnt before the tlast edge increments it
   assign done_now = (frames != 8'd0) && (run_cnt + 8'd1 == frames);
   assign run_done = (frames != 8'd0) && (run_cnt == frames);

`ifdef FRAME_TX_LFSR_EN
   logic [15:0] lfsr;
   logic        fb;

   assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          lfsr <= '0;
      else if (start_acc)                 lfsr <= 16'hACE1;
      else if (state == ST_PAYLOAD && hs) lfsr <= {fb, lfsr[15:1]};
   end

   assign pay_word = lfsr;
`else
   assign pay_word = {frames_sent, pcnt};
`endif

   always_comb begin
      tdata = '0;
      if (state == ST_HEADER) begin
         case (beat)
            4'd0, 4'd1:        tdata = PREAMBLE_WORD;
            4'd2:              tdata = SFD_WORD;
            DST_BEAT0:         tdata = sh_dst[15:0];
            DST_BEAT0 + 4'd1:  tdata = sh_dst[31:16];
            DST_BEAT0 + 4'd2:  tdata = sh_dst[47:32];
            SRC_BEAT0:         tdata = sh_src[15:0];
            SRC_BEAT0 + 4'd1:  tdata = sh_src[31:16];
            SRC_BEAT0 + 4'd2:  tdata = sh_src[47:32];
            ETYPE_BEAT:        tdata = sh_etype;
            default:           tdata = '0;
         endcase
      end else if (state == ST_PAYLOAD) begin
         tdata = pay_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // capture marks every edge on which beat 0 becomes presented
   always_comb begin
      state_n = state;
      capture = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_req) begin
               state_n = ST_HEADER;
               capture = 1'b1;
            end
         end
         ST_HEADER: begin
            if (hs && beat == HDR_BEATS - 4'd1)
               state_n = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (last_hs) begin
               if (ifg != 8'd0) begin
                  state_n = ST_GAP;
               end else if (done_now || stopping) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_HEADER;
                  capture = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gcnt == 8'd0) begin
               if (run_done || stopping) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_HEADER;
                  capture = 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat        <= '0;
         pcnt        <= '0;
         gcnt        <= '0;
         run_cnt     <= '0;
         frames_sent <= '0;
         acc         <= '0;
         csum        <= '0;
         stop_pend   <= 1'b0;
      end else begin
         if (start_acc) run_cnt <= '0;

         if (state == ST_HEADER && hs) begin
            beat <= beat + 4'd1;
            if (beat == HDR_BEATS - 4'd1) pcnt <= '0;
         end

         if (state == ST_PAYLOAD && hs) begin
            acc  <= acc + {16'd0, tdata};
            pcnt <= pcnt + 8'd1;
            if (tlast) begin
               csum        <= acc + {16'd0, tdata};
               frames_sent <= frames_sent + 8'd1;
               run_cnt     <= run_cnt + 8'd1;
               gcnt        <= ifg - 8'd1;
            end
         end

         if (state == ST_GAP && gcnt != 8'd0)
            gcnt <= gcnt - 8'd1;

         // placed last so a back-to-back restart wins
         if (capture) begin
            beat <= '0;
            acc  <= '0;
         end

         if (state_n == ST_IDLE) stop_pend <= 1'b0;
         else if (stop_req)      stop_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter.
// Each scenario task drives stimulus and checks its own results.
module tb_frame_transmitter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   frame_transmitter_if ifc ();

   frame_transmitter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   logic [15:0] cap_data [$];
   logic        cap_last [$];
   int          cap_cyc  [$];
   int          stall_bad;

   logic [15:0] exp1 [14] = '{
      16'h5555, 16'h5555, 16'h55D5, 16'h0201, 16'h0403,
      16'h0605, 16'h0B0A, 16'h0D0C, 16'h0F0E, 16'h0800,
      16'h0000, 16'h0001, 16'h0002, 16'h0003
   };

   task automatic do_reset();
      ifc.chipselect = 1'b0;
      ifc.write = 1'b0;
      ifc.read = 1'b0;
      ifc.address = '0;
      ifc.writedata = '0;
      ifc.egress_port_tready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [7:0] a,
                            input logic [7:0] d);
      @(negedge clk);
      ifc.chipselect = 1'b1;
      ifc.write = 1'b1;
      ifc.address = a;
      ifc.writedata = d;
      @(negedge clk);
      ifc.chipselect = 1'b0;
      ifc.write = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a,
                           output logic [7:0] d);
      @(negedge clk);
      ifc.chipselect = 1'b1;
      ifc.read = 1'b1;
      ifc.address = a;
      @(negedge clk);
      d = ifc.readdata;
      ifc.chipselect = 1'b0;
      ifc.read = 1'b0;
   endtask

   task automatic config_std(input logic [7:0] len,
                             input logic [7:0] ifg,
                             input logic [7:0] nfr);
      for (int i = 0; i < 6; i++) begin
         bus_write(8'(i), 8'(i + 1));
         bus_write(8'(i + 6), 8'(i + 10));
      end
      bus_write(8'd12, 8'h00);
      bus_write(8'd13, 8'h08);
      bus_write(8'd14, len);
      bus_write(8'd15, ifg);
      bus_write(8'd16, nfr);
   endtask

   // Records handshaked beats from the current negedge on. mode 1
   // drives tready 1,0,0 repeating. Optionally writes one register
   // once wr_beat beats have been taken.
   task automatic collect(input int budget, input int nlast,
                          input int tail, input int mode,
                          input int wr_beat,
                          input logic [7:0] wr_a,
                          input logic [7:0] wr_d,
                          output int timeout);
      int lasts = 0;
      int cyc = 0;
      int extra = 0;
      bit done = 0;
      bit wrote = 0;
      bit stalled = 0;
      logic [15:0] pd = '0;
      logic pl = 1'b0;
      cap_data.delete();
      cap_last.delete();
      cap_cyc.delete();
      stall_bad = 0;
      timeout = 0;
      while (!done) begin
         ifc.egress_port_tready = (mode == 0) ? 1'b1
                                : ((cyc % 3) == 0);
         ifc.chipselect = 1'b0;
         ifc.write = 1'b0;
         if (stalled && (ifc.egress_port_tvalid !== 1'b1 ||
             ifc.egress_port_tdata !== pd ||
             ifc.egress_port_tlast !== pl))
            stall_bad++;
         if (wr_beat >= 0 && !wrote &&
             cap_data.size() == wr_beat) begin
            ifc.chipselect = 1'b1;
            ifc.write = 1'b1;
            ifc.address = wr_a;
            ifc.writedata = wr_d;
            wrote = 1;
         end
         if (ifc.egress_port_tvalid && ifc.egress_port_tready) begin
            cap_data.push_back(ifc.egress_port_tdata);
            cap_last.push_back(ifc.egress_port_tlast);
            cap_cyc.push_back(cyc);
            if (ifc.egress_port_tlast) lasts++;
         end
         stalled = ifc.egress_port_tvalid &&
                   !ifc.egress_port_tready;
         pd = ifc.egress_port_tdata;
         pl = ifc.egress_port_tlast;
         cyc++;
         if (lasts >= nlast) extra++;
         if (extra > tail) begin
            done = 1;
         end else if (cyc >= budget) begin
            done = 1;
            timeout = 1;
         end else begin
            @(negedge clk);
         end
      end
      ifc.chipselect = 1'b0;
      ifc.write = 1'b0;
      ifc.egress_port_tready = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      checks++;
      if (ifc.egress_port_tvalid !== 1'b0 ||
          ifc.egress_port_tlast !== 1'b0 ||
          ifc.egress_port_tdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_stream got v=%b l=%b d=%h want 0 0 0000",
                  ifc.egress_port_tvalid, ifc.egress_port_tlast,
                  ifc.egress_port_tdata);
      end
      checks++;
      if (ifc.readdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_readdata got=%h want=00", ifc.readdata);
      end
      bus_read(8'd18, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL reset_status got=%h want=00", d);
      end
      bus_read(8'd14, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL reset_len got=%h want=00", d);
      end
   endtask

   task automatic test_basic();
      int to;
      logic [7:0] d;
      do_reset();
      config_std(8'd4, 8'd0, 8'd1);
      bus_read(8'd14, d);
      checks++;
      if (d !== 8'h04) begin
         errors++;
         $display("FAIL basic_len_rb got=%h want=04", d);
      end
      bus_write(8'd17, 8'h01);
      collect(200, 1, 10, 0, -1, 8'h0, 8'h0, to);
      checks++;
      if (to !== 0 || cap_data.size() !== 14) begin
         errors++;
         $display("FAIL basic_count got=%0d to=%0d want=14",
                  cap_data.size(), to);
      end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (cap_data[i] !== exp1[i] ||
             cap_last[i] !== (i == 13)) begin
            errors++;
            $display("FAIL basic_beat%0d got=%h/%b want=%h/%b",
                     i, cap_data[i], cap_last[i], exp1[i], i == 13);
         end
      end
      bus_read(8'd20, d);
      checks++;
      if (d !== 8'h06) begin
         errors++;
         $display("FAIL basic_csum0 got=%h want=06", d);
      end
      bus_read(8'd21, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL basic_csum1 got=%h want=00", d);
      end
      bus_read(8'd19, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL basic_sent got=%h want=01", d);
      end
      bus_read(8'd18, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL basic_busy got=%h want=00", d);
      end
      bus_read(8'd40, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL basic_unmapped got=%h want=00", d);
      end
   endtask

   task automatic test_backpressure();
      int to;
      int bad = 0;
      logic [7:0] d;
      do_reset();
      config_std(8'd4, 8'd0, 8'd1);
      bus_write(8'd17, 8'h01);
      collect(300, 1, 5, 1, -1, 8'h0, 8'h0, to);
      checks++;
      if (to !== 0 || cap_data.size() !== 14) begin
         errors++;
         $display("FAIL bp_count got=%0d to=%0d want=14",
                  cap_data.size(), to);
      end
      for (int i = 0; i < 14; i++)
         if (cap_data[i] !== exp1[i] || cap_last[i] !== (i == 13))
            bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bp_beats got=%0d_bad want=0", bad);
      end
      checks++;
      if (stall_bad !== 0) begin
         errors++;
         $display("FAIL bp_stable got=%0d want=0", stall_bad);
      end
      bus_read(8'd20, d);
      checks++;
      if (d !== 8'h06) begin
         errors++;
         $display("FAIL bp_csum got=%h want=06", d);
      end
   endtask

   task automatic test_multi();
      int to;
      logic [7:0] d;
      do_reset();
      config_std(8'd4, 8'd5, 8'd3);
      bus_write(8'd17, 8'h01);
      collect(400, 3, 10, 0, -1, 8'h0, 8'h0, to);
      checks++;
      if (to !== 0 || cap_data.size() !== 42) begin
         errors++;
         $display("FAIL multi_count got=%0d to=%0d want=42",
                  cap_data.size(), to);
      end
      for (int f = 0; f < 2; f++) begin
         checks++;
         if (cap_cyc[14 * f + 14] - cap_cyc[14 * f + 13] !== 6) begin
            errors++;
            $display("FAIL multi_gap%0d got=%0d want=6", f,
                     cap_cyc[14 * f + 14] - cap_cyc[14 * f + 13]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_data[24 + k] !== 16'(16'h0100 + k)) begin
            errors++;
            $display("FAIL multi_pay%0d got=%h want=%h", k,
                     cap_data[24 + k], 16'(16'h0100 + k));
         end
      end
      bus_read(8'd19, d);
      checks++;
      if (d !== 8'h03) begin
         errors++;
         $display("FAIL multi_sent got=%h want=03", d);
      end
      bus_read(8'd21, d);
      checks++;
      if (d !== 8'h08) begin
         errors++;
         $display("FAIL multi_csum1 got=%h want=08", d);
      end
      bus_read(8'd18, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL multi_busy got=%h want=00", d);
      end
   endtask

   task automatic test_stop();
      int to;
      logic [7:0] d;
      do_reset();
      bus_write(8'd17, 8'h02);
      bus_read(8'd18, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL stop_idle got=%h want=00", d);
      end
      config_std(8'd4, 8'd0, 8'd0);
      bus_write(8'd17, 8'h01);
      collect(300, 2, 20, 0, 16, 8'd17, 8'h02, to);
      checks++;
      if (to !== 0 || cap_data.size() !== 28) begin
         errors++;
         $display("FAIL stop_count got=%0d to=%0d want=28",
                  cap_data.size(), to);
      end
      checks++;
      if (cap_last[27] !== 1'b1 || cap_data[27] !== 16'h0103) begin
         errors++;
         $display("FAIL stop_last got=%h/%b want=0103/1",
                  cap_data[27], cap_last[27]);
      end
      bus_read(8'd18, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL stop_busy got=%h want=00", d);
      end
      do_reset();
      config_std(8'd4, 8'd0, 8'd0);
      bus_write(8'd17, 8'h03);
      repeat (4) @(negedge clk);
      checks++;
      if (ifc.egress_port_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL stop_start_both got=%b want=0",
                  ifc.egress_port_tvalid);
      end
   endtask

   task automatic test_len0();
      int to;
      logic [7:0] d;
      do_reset();
      config_std(8'd0, 8'd0, 8'd2);
      bus_write(8'd17, 8'h01);
      collect(200, 2, 5, 0, -1, 8'h0, 8'h0, to);
      checks++;
      if (to !== 0 || cap_data.size() !== 22) begin
         errors++;
         $display("FAIL len0_count got=%0d to=%0d want=22",
                  cap_data.size(), to);
      end
      checks++;
      if (cap_last[10] !== 1'b1 || cap_data[21] !== 16'h0100 ||
          cap_last[21] !== 1'b1 || cap_last[9] !== 1'b0) begin
         errors++;
         $display("FAIL len0_last got=%b%b%b d=%h want=011 0100",
                  cap_last[9], cap_last[10], cap_last[21],
                  cap_data[21]);
      end
      bus_read(8'd21, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL len0_csum got=%h want=01", d);
      end
   endtask

   task automatic test_midframe_reset();
      int to;
      logic [7:0] d;
      do_reset();
      config_std(8'd4, 8'd0, 8'd2);
      bus_write(8'd17, 8'h01);
      collect(200, 2, 5, 0, 1, 8'd0, 8'hAA, to);
      checks++;
      if (to !== 0 || cap_data[3] !== 16'h0201 ||
          cap_data[17] !== 16'h02AA) begin
         errors++;
         $display("FAIL mid_dst got=%h,%h to=%0d want=0201,02AA",
                  cap_data[3], cap_data[17], to);
      end
      bus_write(8'd16, 8'h00);
      bus_write(8'd17, 8'h01);
      repeat (12) @(negedge clk);
      checks++;
      if (ifc.egress_port_tvalid !== 1'b1 ||
          ifc.egress_port_tdata !== 16'h0202) begin
         errors++;
         $display("FAIL mid_payload got=%b/%h want=1/0202",
                  ifc.egress_port_tvalid, ifc.egress_port_tdata);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ifc.egress_port_tvalid !== 1'b0 ||
          ifc.egress_port_tdata !== 16'h0) begin
         errors++;
         $display("FAIL mid_async got=%b/%h want=0/0000",
                  ifc.egress_port_tvalid, ifc.egress_port_tdata);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ifc.readdata !== 8'h00) begin
         errors++;
         $display("FAIL mid_rd got=%h want=00", ifc.readdata);
      end
      bus_read(8'd19, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL mid_sent got=%h want=00", d);
      end
      bus_read(8'd20, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL mid_csum got=%h want=00", d);
      end
      bus_read(8'd0, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL mid_dst0 got=%h want=00", d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_multi();
      test_stop();
      test_len0();
      test_midframe_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_transmitter.md
Name: frame_transmitter

Overview:
- Avalon-MM-configured AXI-stream frame source. It emits 16-bit-beat frames with the same layout that frame_receptor consumes: 3 preamble/SFD beats, 3 destination-MAC beats, 3 source-MAC beats, 1 ethertype beat, then N payload beats.
- Used as the on-chip traffic generator feeding the packet filter ingress and loopback benches.
- Reports the payload checksum and frame count in the same format the receptor uses, so software can compare the two ends directly.

Parameters:
- PREAMBLE_WORD, 16'h5555: value of beats 0 and 1.
- SFD_WORD, 16'h55D5: value of beat 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- writedata  in  8  Avalon write data.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon chipselect.
- address  in  8  Avalon byte address.
- read  in  1  Avalon read strobe.
- readdata  out  8  Avalon read data, registered.
- egress_port_tdata  out  16  stream data.
- egress_port_tvalid  out  1  stream valid.
- egress_port_tready  in  1  stream ready.
- egress_port_tlast  out  1  last payload beat.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
  - Everything clears on reset: all registers 0, FSM IDLE, readdata 0, tvalid 0, tlast 0, tdata 0.
  - Reset mid-frame drops tvalid immediately. No partial-frame completion.
- Register map, addresses 0-23:
  - 0-5 RW: dst MAC bytes.
  - 6-11 RW: src MAC bytes.
  - 12-13 RW: ethertype lo/hi.
  - 14 RW: payload length in beats; 0 is treated as 1.
  - 15 RW: inter-frame gap in cycles.
  - 16 RW: frames per run; 0 means continuous.
  - 17 W: control. bit0 = start (self-clearing, reads 0). bit1 = stop request.
  - 18 R: status. bit0 = busy, bit1 = stop pending.
  - 19 R: frames sent, 8-bit, wraps.
  - 20-23 R: checksum of the last completed frame, little-endian.
  - Writes to read-only or unmapped addresses are ignored.
- Read timing: readdata is updated one cycle after chipselect&&read. It is 8'h00 in any cycle without a read, and 8'h00 for unmapped addresses.
- Beat contents:
  - beats 3, 4, 5 = {b1,b0}, {b3,b2}, {b5,b4} of dst MAC.
  - beats 6-8 = the same pairing applied to src MAC.
  - beat 9 = {hi,lo} ethertype.
  - beats 10 onward = payload.
- Shadowing: MAC, ethertype and length registers are copied into shadow registers when beat 0 is first presented. A register write mid-frame affects only the next frame.
- FSM states: IDLE, HEADER (beat index 0-9), PAYLOAD, GAP.
  - IDLE -> HEADER when start=1. Start also clears the run counter. Start while busy is ignored.
  - HEADER -> PAYLOAD after the beat-9 handshake.
  - PAYLOAD -> GAP on the tlast handshake.
  - GAP -> HEADER when the gap counter expires and the run is not done and no stop is pending. Otherwise GAP -> IDLE.
  - A gap of 0 presents the next beat 0 in the cycle right after the tlast handshake; GAP is skipped.
  - Stop finishes the current frame, then goes to IDLE. Stop in IDLE is a no-op.
- Handshake rules: strict AXI-stream.
  - The beat index advances only on tvalid&&tready.
  - While tvalid=1 and tready=0, tdata and tlast are held stable and tvalid is not withdrawn.
  - tvalid=0 in IDLE and GAP.
  - tlast=1 only on the final payload beat.
- Payload pattern: word k = {frames_sent[7:0], k[7:0]}, k from 0.
- Checksum: a 32-bit accumulator of zero-extended payload words, mod 2^32. It clears at beat 0 and is latched to regs 20-23 on the tlast handshake. frames_sent increments on the same edge.
- Run done: the run count equals reg 16 (when nonzero) after a tlast handshake.
- Simultaneous events: a register write and a handshake in the same cycle both take effect, and the write affects only the next shadow copy. Start and stop written together: stop wins, no frame is sent.

Optional Feature:
- Macro: FRAME_TX_LFSR_EN.
- When defined, payload comes from a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1.
  - Seeded to 16'hACE1 on start.
  - Advances once per payload handshake and continues across frames.
- When undefined, the incrementing pattern above is used and no LFSR logic is built.

Decomposition:
- Shared package frame_pkg, used by both this block and frame_receptor:
  - Beat-index constants: HDR_BEATS=10, DST_BEAT0=3, SRC_BEAT0=6, ETYPE_BEAT=9.
  - The register address constants.
  - The FSM state typedef.
- One sub-module, frame_tx_regs: Avalon register file, shadow capture and readback mux. The FSM and datapath stay in the top module.

Test Plan:
- Reset, then dst=01:02:03:04:05:06, src=0A..0F, etype=0x0800, len=4, ifg=0, frames=1, start, tready=1:
  - 14 beats: 5555, 5555, 55D5, 0201, 0403, 0605, 0B0A, 0D0C, 0F0E, 0800, 0000, 0001, 0002, 0003.
  - tlast on beat 13. Checksum reads 6. Frames sent reads 1. Busy returns to 0.
- Same config with tready toggled 1,0,0,1,...:
  - tdata and tlast are held stable while tready=0.
  - Identical beat sequence and checksum 6.
- frames=3, ifg=5:
  - Exactly 5 tvalid=0 cycles between each tlast handshake and the next beat 0.
  - Second frame payload is 0100..0103.
  - Frames sent reads 3.
- frames=0 (continuous), then stop written during frame 2's header:
  - Frame 2 completes with tlast.
  - No beat 0 follows. Busy=0.
- len=0: the single payload beat carries tlast, and the checksum equals that word.
- Mid-frame dst write, and reset asserted during payload:
  - The current frame keeps its old dst MAC; the new value appears in the next frame.
  - Reset drops tvalid asynchronously, and readdata and all counters read 0 afterwards.
